// File: rtl/cp0_irq_timer_pkg.sv
// Shared definitions for the CP0 interrupt/timer unit.
//  - CP0 register numbers and select values decoded by the unit.
//  - Read-mux selector enum and the address decode helpers.
package cp0_irq_timer_pkg;

  localparam int unsigned REG_NUM_W = 5;
  localparam int unsigned SEL_W     = 3;

  localparam logic [REG_NUM_W-1:0] REG_COUNT   = 5'd9;
  localparam logic [REG_NUM_W-1:0] REG_COMPARE = 5'd11;
  localparam logic [REG_NUM_W-1:0] REG_CAUSE   = 5'd13;

  localparam logic [SEL_W-1:0] SEL_BASE         = 3'd0;
  // Cause select 1 exposes the edge latches and takes write-1-to-clear.
  localparam logic [SEL_W-1:0] CAUSE_SEL_IRQCLR = 3'd1;

  typedef enum logic [1:0] {
    RD_NONE    = 2'd0,
    RD_COUNT   = 2'd1,
    RD_COMPARE = 2'd2,
    RD_IRQCLR  = 2'd3
  } rd_sel_e;

  function automatic logic reg_hit(input logic [REG_NUM_W-1:0] reg_num,
                                   input logic [SEL_W-1:0]     sel,
                                   input logic [REG_NUM_W-1:0] want_reg,
                                   input logic [SEL_W-1:0]     want_sel);
    return (reg_num == want_reg) && (sel == want_sel);
  endfunction

  function automatic rd_sel_e decode_rd(input logic [REG_NUM_W-1:0] reg_num,
                                        input logic [SEL_W-1:0]     sel);
    rd_sel_e r;
    if (reg_hit(reg_num, sel, REG_COUNT, SEL_BASE)) begin
      r = RD_COUNT;
    end else if (reg_hit(reg_num, sel, REG_COMPARE, SEL_BASE)) begin
      r = RD_COMPARE;
    end else if (reg_hit(reg_num, sel, REG_CAUSE, CAUSE_SEL_IRQCLR)) begin
      r = RD_IRQCLR;
    end else begin
      r = RD_NONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/cp0_irq_timer_if.sv
// CP0 access bus between WB (master) and the interrupt/timer unit (slave).
//  wen/reg_num/sel/reg_in : MTC0 commit and register address (also MFC0 address)
//  status_im/ie/exl       : Status fields gating the interrupt request
//  reg_out                : MFC0 read data
//  int_req                : interrupt to be taken by WB
interface cp0_irq_timer_if;
  import cp0_irq_timer_pkg::*;

  logic                 wen;
  logic [REG_NUM_W-1:0] reg_num;
  logic [SEL_W-1:0]     sel;
  logic [31:0]          reg_in;
  logic [7:0]           status_im;
  logic                 status_ie;
  logic                 status_exl;
  logic [31:0]          reg_out;
  logic                 int_req;

  modport master (
    output wen, reg_num, sel, reg_in, status_im, status_ie, status_exl,
    input  reg_out, int_req
  );

  modport slave (
    input  wen, reg_num, sel, reg_in, status_im, status_ie, status_exl,
    output reg_out, int_req
  );

endinterface

// File: rtl/cp0_irq_timer_irq_sync.sv
// One external interrupt line: synchroniser, rising-edge detect and a sticky
// latch whose clear loses to a simultaneous set.
//  clk, reset : clock, async active-low reset
//  d          : asynchronous interrupt input
//  clr        : write-1-to-clear strobe for the latch
//  pend       : pending level fed to Cause.IP (latch in edge mode, synced level otherwise)
//  latched    : latch state for readback (0 in level mode)
module cp0_irq_timer_irq_sync #(
  parameter int unsigned STAGES = 2,
  parameter bit          EDGE   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  input  logic clr,
  output logic pend,
  output logic latched
);

  logic [STAGES-1:0] sync_r;
  logic              s_d_r;
  logic              latch_r;
  logic              s_s;
  logic              rise_s;

  assign s_s    = sync_r[STAGES-1];
  assign rise_s = s_s & ~s_d_r;

  // Synchroniser chain plus one-cycle delayed copy for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_r <= {STAGES{1'b0}};
      s_d_r  <= 1'b0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
      s_d_r  <= s_s;
    end
  end

  // Edge latch: a rising edge on the same clock as a clear keeps the latch set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      latch_r <= 1'b0;
    end else if (rise_s) begin
      latch_r <= 1'b1;
    end else if (clr) begin
      latch_r <= 1'b0;
    end else begin
      latch_r <= latch_r;
    end
  end

  assign pend    = EDGE ? latch_r : s_s;
  assign latched = EDGE ? latch_r : 1'b0;

endmodule

// File: rtl/cp0_irq_timer.sv
// CP0 interrupt/timer unit: Count (with prescaler and debug freeze), Compare,
// Cause.TI, Cause.IP assembly from synchronised external lines, interrupt
// request and the MFC0 read mux for the registers it owns.
//  clk, reset : clock, async active-low reset
//  bus        : CP0 access bus (slave side): MTC0 commits, Status, reg_out, int_req
//  count_stop : freezes Count and the prescaler
//  irq_in     : asynchronous external interrupt lines
//  count, compare, cause_ti, cause_ip : architectural register state
module cp0_irq_timer
  import cp0_irq_timer_pkg::*;
#(
  parameter int unsigned NUM_HW_IRQ  = 5,
  parameter logic [5:0]  EDGE_MASK   = 6'h0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned COUNT_DIV   = 2,
  parameter int unsigned TIMER_IP    = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  cp0_irq_timer_if.slave        bus,
  input  logic                  count_stop,
  input  logic [NUM_HW_IRQ-1:0] irq_in,
  output logic [31:0]           count,
  output logic [31:0]           compare,
  output logic                  cause_ti,
  output logic [7:0]            cause_ip
);

  localparam int unsigned DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  logic [DIV_W-1:0]      div_r;
  logic                  wr_count_s;
  logic                  wr_compare_s;
  logic                  wr_cause_s;
  logic                  wr_irqclr_s;
  logic                  tick_s;
  logic [NUM_HW_IRQ-1:0] clr_s;
  logic [NUM_HW_IRQ-1:0] hw_pend_s;
  logic [NUM_HW_IRQ-1:0] latched_s;
  logic [5:0]            pend_ext_s;
  logic [7:0]            ip_next_s;
  logic [31:0]           rd_data_s;
  rd_sel_e               rd_sel_s;

  assign wr_count_s   = bus.wen & reg_hit(bus.reg_num, bus.sel, REG_COUNT, SEL_BASE);
  assign wr_compare_s = bus.wen & reg_hit(bus.reg_num, bus.sel, REG_COMPARE, SEL_BASE);
  assign wr_cause_s   = bus.wen & reg_hit(bus.reg_num, bus.sel, REG_CAUSE, SEL_BASE);
  assign wr_irqclr_s  = bus.wen & reg_hit(bus.reg_num, bus.sel, REG_CAUSE, CAUSE_SEL_IRQCLR);
  assign tick_s       = ~count_stop & (div_r == DIV_LAST);
  assign clr_s        = wr_irqclr_s ? bus.reg_in[NUM_HW_IRQ-1:0] : {NUM_HW_IRQ{1'b0}};

  // Prescaler: restarts on a Count write so the next increment is a full period away
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_r <= {DIV_W{1'b0}};
    end else if (wr_count_s) begin
      div_r <= {DIV_W{1'b0}};
    end else if (!count_stop) begin
      div_r <= (div_r == DIV_LAST) ? {DIV_W{1'b0}} : div_r + DIV_W'(1'b1);
    end else begin
      div_r <= div_r;
    end
  end

  // Count: software write overrides the prescaled increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 32'd0;
    end else if (wr_count_s) begin
      count <= bus.reg_in;
    end else if (tick_s) begin
      count <= count + 32'd1;
    end else begin
      count <= count;
    end
  end

  // Compare and sticky TI; a Compare write on the match clock suppresses the set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      compare  <= 32'hFFFF_FFFF;
      cause_ti <= 1'b0;
    end else if (wr_compare_s) begin
      compare  <= bus.reg_in;
      cause_ti <= 1'b0;
    end else begin
      compare  <= compare;
      cause_ti <= cause_ti | (count == compare);
    end
  end

  for (genvar i = 0; i < NUM_HW_IRQ; i++) begin : g_line
    cp0_irq_timer_irq_sync #(
      .STAGES (SYNC_STAGES),
      .EDGE   (EDGE_MASK[i])
    ) u_sync (
      .clk     (clk),
      .reset   (reset),
      .d       (irq_in[i]),
      .clr     (clr_s[i]),
      .pend    (hw_pend_s[i]),
      .latched (latched_s[i])
    );
  end

  // Next Cause.IP: software bits, hardware lines, timer ORed into its chosen bit
  always_comb begin
    pend_ext_s = 6'd0;
    pend_ext_s[NUM_HW_IRQ-1:0] = hw_pend_s;
    ip_next_s = {pend_ext_s, 2'b00};
    if (wr_cause_s) begin
      ip_next_s[1:0] = bus.reg_in[9:8];
    end else begin
      ip_next_s[1:0] = cause_ip[1:0];
    end
    ip_next_s[TIMER_IP] = ip_next_s[TIMER_IP] | cause_ti;
  end

  // Cause.IP register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cause_ip <= 8'd0;
    end else begin
      cause_ip <= ip_next_s;
    end
  end

  // MFC0 read mux for the registers owned here
  always_comb begin
    rd_sel_s  = decode_rd(bus.reg_num, bus.sel);
    rd_data_s = 32'd0;
    case (rd_sel_s)
      RD_COUNT:   rd_data_s = count;
      RD_COMPARE: rd_data_s = compare;
      RD_IRQCLR:  rd_data_s[NUM_HW_IRQ-1:0] = latched_s;
      default:    rd_data_s = 32'd0;
    endcase
  end

  assign bus.reg_out = rd_data_s;
  assign bus.int_req = bus.status_ie & ~bus.status_exl & (|(cause_ip & bus.status_im));

endmodule
